mul_iter_unit: RTL and testbench
================================

Name: mul_iter_unit

Overview:
- Multi-cycle radix-2 shift-add multiplier that executes requests encoded with the shared mul_ops type (mul, mulh, mulhsu, mulhu).
- Sits behind the decode/issue stage that produces mul_ops.
- Receives operands over a valid/ready request channel and returns results over a valid/ready response channel.
- Supports a flush that kills the in-flight operation.

Parameters:
- XLEN, 32, operand and result width.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of any in-flight or pending operation
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_op  input  3  operation, func_types::mul_ops encoding
- req_a  input  XLEN  multiplicand (rs1)
- req_b  input  XLEN  multiplier (rs2)
- resp_valid  output  1  result present
- resp_ready  input  1  consumer takes result
- resp_data  output  XLEN  result
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: one clock, asynchronous active-low reset (clk, rst_n). While rst_n is low:
  - state = IDLE;
  - req_ready = 1 after release;
  - resp_valid = 0, resp_data = 0, busy = 0;
  - counter and accumulators cleared.
  - Reset mid-operation discards the operation; no response is produced.
- States: IDLE -> CALC -> SIGN -> DONE -> IDLE.
- IDLE:
  - req_ready = !flush.
  - Accept on req_valid & req_ready, then go to CALC.
  - On accept, latch:
    - op;
    - |a| if op in {mulh, mulhsu} and a[XLEN-1]=1, else a;
    - |b| if op == mulh and b[XLEN-1]=1, else b;
    - neg = XOR of the signs used.
  - mul_op treats operands as unsigned; the low half is sign-agnostic.
- CALC:
  - XLEN cycles, one multiplier bit per cycle (LSB first).
  - Accumulate into a 2*XLEN product register.
  - Counter runs 0..XLEN-1; go to SIGN when count == XLEN-1.
- SIGN:
  - One cycle.
  - If neg, product = two's-complement negation over 2*XLEN bits.
  - Select the low XLEN bits for mul_op, the high XLEN bits for the other ops.
  - Register the result into resp_data; go to DONE.
- DONE:
  - resp_valid = 1; resp_data held stable until resp_ready.
  - On resp_valid & resp_ready, go to IDLE.
  - resp_data keeps its last value after the handshake.
- Latency: resp_valid rises exactly XLEN+2 cycles after the accepting edge (34 for XLEN=32).
  - No early-out; latency is data-independent.
  - Throughput: one op per XLEN+3 cycles minimum (IDLE bubble after DONE).
- req_ready is low in every state except IDLE. Requests presented while busy are not accepted and must be held by the producer.
- Undefined req_op codes (3'b100..3'b111): accepted, full latency, resp_data = 0.
- Flush:
  - Any state goes to IDLE at the next edge.
  - resp_valid is 0 from the next cycle; no response is produced for the killed op.
  - flush in IDLE with req_valid: the request is not accepted.
  - flush in DONE in the same cycle as resp_ready: the response is considered consumed; either way, IDLE next.
- Operand sign edge cases:
  - |0x80000000| = 0x80000000 as an unsigned magnitude; the 2*XLEN arithmetic keeps this correct.
  - Operands of 0 give 0 for all ops, including with neg set.

Decomposition:
- func_types (shared package):
  - mul_ops already lives there; no new op codes.
  - Add mul_state_e (IDLE, CALC, SIGN, DONE; 2-bit).
  - Add localparam MUL_ITER_LATENCY = XLEN+2 for the bench and scheduler.
- Sub-module mul_operand_prep (combinational): op + a + b -> magnitudes and neg flag. Keeps the FSM file focused on sequencing.

Test Plan:
- mul_op, a=7, b=0xFFFFFFFD (-3) -> resp_data=0xFFFFFFEB, resp_valid exactly 34 cycles after accept.
- mul_op_h, a=b=0x80000000 -> 0x40000000; mul_op_h, a=0xFFFFFFFF, b=0x00000002 -> 0xFFFFFFFF.
- mul_op_hu, a=b=0xFFFFFFFF -> 0xFFFFFFFE; mul_op_hsu, a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- Backpressure:
  - Hold resp_ready=0 for 10 cycles after resp_valid: resp_data is stable and req_ready stays 0.
  - Raise resp_ready: IDLE next cycle, req_ready=1.
  - A second request held valid throughout is accepted then.
- Flush and reset:
  - Assert flush at CALC cycle 5: no resp_valid ever for that op, req_ready=1 the next cycle; a new mul_op 3*4 returns 0x0000000C.
  - Assert rst_n=0 mid-CALC asynchronously: all outputs are 0 immediately.
- Undefined op 3'b101, a=5, b=6 -> resp_data=0 after 34 cycles. Random mix of 10k ops against a reference model, with random req_valid/resp_ready stalls.

Source files
------------

// File: rtl/func_types.sv
// rtl/func_types.sv - shared functional-unit op encodings and multiplier sequencing types
package func_types;

    localparam int MUL_XLEN         = 32;
    localparam int MUL_ITER_LATENCY = MUL_XLEN + 2;

    typedef enum logic [2:0] {
        mul_op     = 3'b000,
        mul_op_h   = 3'b001,
        mul_op_hsu = 3'b010,
        mul_op_hu  = 3'b011
    } mul_ops;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } mul_state_e;

endpackage

// File: rtl/mul_operand_prep.sv
// rtl/mul_operand_prep.sv - operand magnitudes and result sign for the iterative multiplier
module mul_operand_prep
    import func_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] mag_a,
    output logic [XLEN-1:0] mag_b,
    output logic            neg
);

    logic a_neg;
    logic b_neg;

    // Undefined op codes fall through as unsigned; their result is zeroed later.
    assign a_neg = ((op == mul_op_h) || (op == mul_op_hsu)) && a[XLEN-1];
    assign b_neg = (op == mul_op_h) && b[XLEN-1];

    // -0x80000000 wraps to itself, which is the correct unsigned magnitude.
    assign mag_a = a_neg ? -a : a;
    assign mag_b = b_neg ? -b : b;
    assign neg   = a_neg ^ b_neg;

endmodule

// File: rtl/mul_iter_unit.sv
// rtl/mul_iter_unit.sv - radix-2 shift-add multiplier with valid/ready request and response
module mul_iter_unit
    import func_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    mul_state_e        state;
    mul_state_e        state_nxt;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   mcand_q;
    logic [2*XLEN-1:0] prod_q;
    logic              neg_q;
    logic [CW-1:0]     cnt_q;

    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              prep_neg;
    logic              accept;
    logic [XLEN:0]     add_sum;
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   result_sel;

    mul_operand_prep #(.XLEN(XLEN)) u_prep (
        .op    (req_op),
        .a     (req_a),
        .b     (req_b),
        .mag_a (mag_a),
        .mag_b (mag_b),
        .neg   (prep_neg)
    );

    assign accept = req_valid && req_ready;

    // Low half of prod_q starts as the multiplier and drains out as the product shifts in.
    assign add_sum     = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q & {XLEN{prod_q[0]}}};
    assign prod_signed = neg_q ? -prod_q : prod_q;

    always_comb begin
        result_sel = '0;
        if (op_q == mul_op) begin
            result_sel = prod_signed[XLEN-1:0];
        end else if ((op_q == mul_op_h) || (op_q == mul_op_hsu) || (op_q == mul_op_hu)) begin
            result_sel = prod_signed[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = rst_n && !flush;
                if (accept) state_nxt = CALC;
            end
            CALC: if (cnt_q == CW'(XLEN-1)) state_nxt = SIGN;
            SIGN: state_nxt = DONE;
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            resp_data <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= req_op;
                        mcand_q <= mag_a;
                        prod_q  <= {{XLEN{1'b0}}, mag_b};
                        neg_q   <= prep_neg;
                        cnt_q   <= '0;
                    end
                end
                CALC: begin
                    prod_q <= {add_sum, prod_q[XLEN-1:1]};
                    cnt_q  <= cnt_q + CW'(1);
                end
                SIGN: if (!flush) resp_data <= result_sel;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter_unit.sv
// tb/tb_mul_iter_unit.sv - directed and small random checks for mul_iter_unit
module tb_mul_iter_unit;
    import func_types::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        busy;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mul_iter_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa;
        logic [63:0] xb;
        logic [63:0] p;
        xa = {32'b0, a};
        xb = {32'b0, b};
        if ((op == 3'd1 || op == 3'd2) && a[31]) xa = {32'hFFFFFFFF, a};
        if (op == 3'd1 && b[31]) xb = {32'hFFFFFFFF, b};
        p = xa * xb;
        case (op)
            3'd0:    return p[31:0];
            3'd1,
            3'd2,
            3'd3:    return p[63:32];
            default: return 32'h0;
        endcase
    endfunction

    // Present a request, measure cycles from the accept cycle to resp_valid, then consume.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int pre_stall, input int resp_stall);
        int w;
        int lat;
        repeat (pre_stall) @(negedge clk);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        #1;
        w = 0;
        while (!req_ready && w < 200) begin
            @(negedge clk); #1; w++;
        end
        check({tag, " accept"}, {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 200) begin
            @(negedge clk); lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(MUL_ITER_LATENCY));
        check({tag, " data"}, resp_data, exp);
        repeat (resp_stall) @(negedge clk);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rop;
        int          seen;
        int          lat;

        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_op = 3'd0; req_a = '0; req_b = '0;
        #2;
        check("reset req_ready", {31'b0, req_ready}, 32'd0);
        check("reset resp_valid", {31'b0, resp_valid}, 32'd0);
        check("reset resp_data", resp_data, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post reset req_ready", {31'b0, req_ready}, 32'd1);

        do_op("mul 7*-3", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 0, 0);
        do_op("mulh min*min", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1, 2);
        do_op("mulh -1*2", 3'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 0, 0);
        do_op("mulhu max*max", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 1);
        do_op("mulhsu -1*max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        do_op("mulhsu min*max", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0);
        do_op("mulh 0*-5", 3'd1, 32'h00000000, 32'hFFFFFFFB, 32'h00000000, 0, 0);
        do_op("undef op 5*6", 3'b101, 32'd5, 32'd6, 32'h00000000, 0, 0);

        // Backpressure with a second request held valid throughout
        req_op = 3'd3; req_a = 32'hFFFFFFFF; req_b = 32'hFFFFFFFF; req_valid = 1'b1;
        #1;
        check("bp accept1", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_op = 3'd2; req_a = 32'h80000000; req_b = 32'hFFFFFFFF;
        lat = 1;
        while (!resp_valid && lat < 200) begin
            @(negedge clk); lat++;
        end
        check("bp latency1", 32'(lat), 32'd34);
        check("bp data1", resp_data, 32'hFFFFFFFE);
        held = resp_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp data stable", resp_data, held);
            check("bp req_ready low", {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        #1;
        check("bp idle req_ready", {31'b0, req_ready}, 32'd1);
        check("bp idle busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp accept2 busy", {31'b0, busy}, 32'd1);
        lat = 1;
        while (!resp_valid && lat < 200) begin
            @(negedge clk); lat++;
        end
        check("bp latency2", 32'(lat), 32'd34);
        check("bp data2", resp_data, 32'h80000000);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;

        // Flush mid-CALC
        req_op = 3'd0; req_a = 32'd9; req_b = 32'd9; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush req_ready", {31'b0, req_ready}, 32'd1);
        check("flush busy", {31'b0, busy}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("flush no response", 32'(seen), 32'd0);
        do_op("mul 3*4", 3'd0, 32'd3, 32'd4, 32'h0000000C, 0, 0);

        // Flush in IDLE blocks acceptance
        flush = 1'b1; req_op = 3'd0; req_a = 32'd2; req_b = 32'd2; req_valid = 1'b1;
        #1;
        check("idle flush req_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        check("idle flush busy", {31'b0, busy}, 32'd0);

        // Flush in DONE without resp_ready drops the response
        req_op = 3'd0; req_a = 32'd5; req_b = 32'd5; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 200) begin
            @(negedge clk); lat++;
        end
        check("done flush data", resp_data, 32'd25);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("done flush resp_valid", {31'b0, resp_valid}, 32'd0);
        check("done flush data kept", resp_data, 32'd25);

        // Asynchronous reset mid-CALC
        req_op = 3'd3; req_a = 32'hFFFFFFFF; req_b = 32'd3; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst req_ready", {31'b0, req_ready}, 32'd0);
        check("async rst resp_valid", {31'b0, resp_valid}, 32'd0);
        check("async rst resp_data", resp_data, 32'd0);
        check("async rst busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("rst no response", 32'(seen), 32'd0);
        check("rst req_ready", {31'b0, req_ready}, 32'd1);

        // Small random mix against the reference model
        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 4));
            if (rop == 3'd4) rop = 3'($urandom_range(4, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'h80000000;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'h0;
                default: ;
            endcase
            do_op("random", rop, ra, rb, model(rop, ra, rb),
                  $urandom_range(0, 3), $urandom_range(0, 4));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
